// File: rtl/io_tile_config_chain.sv
// Config chain for one IO tile: LANES-wide serial shadow register, committed into an active register.
// Latency: shift 1 cycle into shadow; config_out replays input after DEPTH shifts; commit lands 1 cycle after pulse.
// Backpressure: none; commits are refused (sticky config_error) until a full DEPTH-shift load has been seen.
module io_tile_config_chain #(
    parameter int CONFIG_WIDTH = 24,
    parameter int LANES        = 1
) (
    input  logic                    config_clock,
    input  logic                    config_reset,
    input  logic [LANES-1:0]        config_in,
    output logic [LANES-1:0]        config_out,
    input  logic                    config_enable,
    input  logic                    config_commit,
    output logic [CONFIG_WIDTH-1:0] config_data,
    output logic                    config_valid,
    output logic                    config_error
);

    localparam int DEPTH = CONFIG_WIDTH / LANES;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // The lanes must tile the config word exactly, otherwise a full load is ill-defined.
    generate
        if ((CONFIG_WIDTH % LANES) != 0) begin : g_bad_lanes
            $error("io_tile_config_chain: CONFIG_WIDTH must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
    logic [CONFIG_WIDTH-1:0] data_q,   data_d;
    logic [CW-1:0]           count_q,  count_d;
    logic                    valid_q,  valid_d;
    logic                    error_q,  error_d;
    state_t                  state_q,  state_d;
    logic                    commit_ok;

    // Next-state: shift, saturating load counter, commit gating, and state derived from the new count.
    always_comb begin
        shadow_d  = shadow_q;
        data_d    = data_q;
        count_d   = count_q;
        valid_d   = valid_q;
        error_d   = error_q;
        commit_ok = config_commit && (state_q == ARMED);

        if (config_enable) begin
            // Concatenate then truncate so LANES == CONFIG_WIDTH needs no special case.
            shadow_d = CONFIG_WIDTH'({shadow_q, config_in});
            if (count_q != DEPTH_C) begin
                count_d = count_q + ONE_C;
            end
        end

        if (config_commit) begin
            if (commit_ok) begin
                // Commit takes the shadow as it stood before any shift on this same edge.
                data_d  = shadow_q;
                valid_d = 1'b1;
                count_d = config_enable ? ONE_C : '0;
            end else begin
                error_d = 1'b1;
            end
        end

        if (count_d == '0) begin
            state_d = IDLE;
        end else if (count_d == DEPTH_C) begin
            state_d = ARMED;
        end else begin
            state_d = LOADING;
        end
    end

    // All chain state updates on one edge; reset discards any partial load immediately.
    always_ff @(posedge config_clock or posedge config_reset) begin
        if (config_reset) begin
            shadow_q <= '0;
            data_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            state_q  <= IDLE;
        end else begin
            shadow_q <= shadow_d;
            data_q   <= data_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            state_q  <= state_d;
        end
    end

    assign config_out   = shadow_q[CONFIG_WIDTH-1 -: LANES];
    assign config_data  = data_q;
    assign config_valid = valid_q;
    assign config_error = error_q;

endmodule

// File: tb/tb_io_tile_config_chain.sv
// Bench for io_tile_config_chain: table of load/commit vectors plus hand-written corner sequences.
// Inputs change on the falling edge, outputs are sampled on the next falling edge.
// config_out is checked against a queue of previously shifted-in bits.
module tb_io_tile_config_chain;

    logic        clk;
    logic        rst;
    logic [0:0]  cin;
    logic [0:0]  cout;
    logic        en;
    logic        cm;
    logic [23:0] data;
    logic        valid;
    logic        err;

    logic [3:0]  in4;
    logic [3:0]  out4;
    logic        en4;
    logic        cm4;
    logic [23:0] data4;
    logic        valid4;
    logic        err4;

    int n_cmp;
    int n_fail;

    logic [23:0] exp_shadow;
    logic        out_q[$];

    io_tile_config_chain #(.CONFIG_WIDTH(24), .LANES(1)) dut (
        .config_clock (clk),
        .config_reset (rst),
        .config_in    (cin),
        .config_out   (cout),
        .config_enable(en),
        .config_commit(cm),
        .config_data  (data),
        .config_valid (valid),
        .config_error (err)
    );

    io_tile_config_chain #(.CONFIG_WIDTH(24), .LANES(4)) dut4 (
        .config_clock (clk),
        .config_reset (rst),
        .config_in    (in4),
        .config_out   (out4),
        .config_enable(en4),
        .config_commit(cm4),
        .config_data  (data4),
        .config_valid (valid4),
        .config_error (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pat;
        int          n;
        logic [23:0] exp_data;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; afterwards the scoreboard checks config_out.
    task automatic step(input logic e, input logic c, input logic d);
        en  = e;
        cm  = c;
        cin = d;
        @(negedge clk);
        if (e) begin
            exp_shadow = {exp_shadow[22:0], d};
            out_q.push_back(d);
            if (out_q.size() == 24) begin
                check("config_out_replay", {31'd0, cout[0]}, {31'd0, out_q.pop_front()});
            end
        end
        en = 1'b0;
        cm = 1'b0;
        cin = 1'b0;
    endtask

    task automatic load(input logic [31:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b0, pat[i]);
        end
    endtask

    // Reset pulse between edges; optionally checks outputs while reset is held, before any edge.
    task automatic do_reset(input bit chk);
        #2 rst = 1'b1;
        #1;
        if (chk) begin
            check("async_rst_data",  {8'd0, data}, 32'd0);
            check("async_rst_valid", {31'd0, valid}, 32'd0);
            check("async_rst_error", {31'd0, err}, 32'd0);
            check("async_rst_out",   {31'd0, cout[0]}, 32'd0);
        end
        #1 rst = 1'b0;
        exp_shadow = '0;
        out_q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] snap;
        logic [23:0] p4;
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 1'b0; cm = 1'b0; cin = 1'b0;
        en4 = 1'b0; cm4 = 1'b0; in4 = 4'h0;
        exp_shadow = '0;

        vecs[0] = '{32'h00A5C3F0, 24, 24'hA5C3F0, 1'b1, 1'b0};
        vecs[1] = '{32'h00FFFFFF, 24, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h00000001, 24, 24'h000001, 1'b1, 1'b0};
        vecs[3] = '{32'h3FA5C3F0, 30, 24'hA5C3F0, 1'b1, 1'b0};
        vecs[4] = '{32'h00123456, 23, 24'h000000, 1'b0, 1'b1};
        vecs[5] = '{32'h00800000, 24, 24'h800000, 1'b1, 1'b0};

        #1;
        check("reset_data",  {8'd0, data}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_error", {31'd0, err}, 32'd0);
        check("reset_out",   {31'd0, cout[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table: reset, load n bits MSB first, commit, compare.
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0);
            load(vecs[v].pat, vecs[v].n);
            step(1'b0, 1'b1, 1'b0);
            check("vec_data",  {8'd0, data}, {8'd0, vecs[v].exp_data});
            check("vec_valid", {31'd0, valid}, {31'd0, vecs[v].exp_valid});
            check("vec_error", {31'd0, err}, {31'd0, vecs[v].exp_err});
        end

        // Second commit with no reload is refused; then reset mid-cycle clears everything.
        step(1'b0, 1'b1, 1'b0);
        check("recommit_error", {31'd0, err}, 32'd1);
        check("recommit_data",  {8'd0, data}, 32'h00800000);
        do_reset(1'b1);

        // Early commit refused with prior load kept; one more shift makes it acceptable.
        load(32'h005A5A5A, 24);
        step(1'b0, 1'b1, 1'b0);
        load(32'h00C0FFEE, 23);
        step(1'b0, 1'b1, 1'b0);
        check("early_error", {31'd0, err}, 32'd1);
        check("early_data",  {8'd0, data}, 32'h005A5A5A);
        check("early_valid", {31'd0, valid}, 32'd1);
        step(1'b1, 1'b0, 1'b1);
        snap = exp_shadow;
        step(1'b0, 1'b1, 1'b0);
        check("late_data",  {8'd0, data}, {8'd0, snap});
        check("late_error", {31'd0, err}, 32'd1);

        // Shift and commit together: pre-shift shadow committed, shift counts as first of new load.
        do_reset(1'b0);
        load(32'h00A5C3F0, 24);
        step(1'b1, 1'b1, 1'b1);
        check("shcm_data",  {8'd0, data}, 32'h00A5C3F0);
        check("shcm_valid", {31'd0, valid}, 32'd1);
        load(32'h00155555, 22);
        step(1'b0, 1'b1, 1'b0);
        check("shcm_23_refused", {31'd0, err}, 32'd1);
        check("shcm_23_data",    {8'd0, data}, 32'h00A5C3F0);
        step(1'b1, 1'b0, 1'b0);
        snap = exp_shadow;
        step(1'b0, 1'b1, 1'b0);
        check("shcm_24_data", {8'd0, data}, {8'd0, snap});

        // Reset mid-load drops valid and restarts the count.
        do_reset(1'b0);
        load(32'h00A5C3F0, 24);
        step(1'b0, 1'b1, 1'b0);
        check("midload_pre_valid", {31'd0, valid}, 32'd1);
        load(32'h000003FF, 10);
        do_reset(1'b0);
        check("midload_valid", {31'd0, valid}, 32'd0);
        check("midload_data",  {8'd0, data}, 32'd0);
        load(32'h00003FFF, 14);
        step(1'b0, 1'b1, 1'b0);
        check("midload_count_restart", {31'd0, err}, 32'd1);
        check("midload_valid2", {31'd0, valid}, 32'd0);

        // Four-lane instance: six nibble shifts of 0x123456, most significant nibble first.
        do_reset(1'b0);
        p4 = 24'h123456;
        for (int i = 5; i >= 0; i--) begin
            in4 = p4[i*4 +: 4];
            en4 = 1'b1;
            @(negedge clk);
        end
        en4 = 1'b0;
        in4 = 4'h0;
        check("l4_pre_data", {8'd0, data4}, 32'd0);
        check("l4_out",      {28'd0, out4}, 32'h1);
        cm4 = 1'b1;
        @(negedge clk);
        cm4 = 1'b0;
        check("l4_data",  {8'd0, data4}, 32'h00123456);
        check("l4_valid", {31'd0, valid4}, 32'd1);
        check("l4_error", {31'd0, err4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
